// File: rtl/bootram_pkg.sv
// rtl/bootram_pkg.sv - boot image constant, FSM states and image lookup helper for bootram_obi
package bootram_pkg;

  localparam int BOOT_IMAGE_LEN = 3;
  localparam int IMG_IDX_W      = (BOOT_IMAGE_LEN > 1) ? $clog2(BOOT_IMAGE_LEN) : 1;

  // Entry 0 sits in the least significant slot: lui t0,0x80000 / addi t1,t0,0 / jr t0
  localparam logic [BOOT_IMAGE_LEN-1:0][31:0] BOOT_IMAGE = {
    32'h00028067,
    32'h00028313,
    32'h800002b7
  };

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_READY  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  function automatic logic [31:0] boot_word(input logic [31:0] idx);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < BOOT_IMAGE_LEN; i++) begin
      if (idx == 32'(i)) w = BOOT_IMAGE[i[IMG_IDX_W-1:0]];
    end
    return w;
  endfunction

endpackage

// File: rtl/bootram_array.sv
// rtl/bootram_array.sv - single-port word array with byte-enabled write and registered, gated read
module bootram_array #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [DATA_W/8-1:0]   be_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int BE_W  = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Read data is forced to zero on non-read cycles so the response bus idles at 0.
  always_comb begin
    rdata_d = '0;
    if (re_i) rdata_d = mem_q[addr_i];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) rdata_q <= '0;
    else         rdata_q <= rdata_d;
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bootram_obi.sv
// rtl/bootram_obi.sv - OBI boot RAM: loads BOOT_IMAGE after reset, then serves req/gnt/rvalid traffic
// Optional write-lock enabled by defining BOOTRAM_LOCK_EN.
module bootram_obi
  import bootram_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [DATA_W/8-1:0]   be_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  err_o,
  input  logic                  lock_i,
  output logic                  locked_o,
  output logic                  init_done_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int BE_W  = DATA_W / 8;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                rvalid_q, rvalid_d;
  logic                err_q, err_d;
  logic                mem_we, mem_re;
  logic [BE_W-1:0]     mem_be;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
`ifdef BOOTRAM_LOCK_EN
  logic                pend_q, pend_d;
`else
  logic                unused_lock;
  assign unused_lock = lock_i;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_o     = 1'b0;
    rvalid_d  = 1'b0;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_be    = be_i;
    mem_addr  = addr_i;
    mem_wdata = wdata_i;
`ifdef BOOTRAM_LOCK_EN
    pend_d    = pend_q;
`endif
    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_be    = '1;
        mem_addr  = cnt_q;
        mem_wdata = DATA_W'(boot_word(32'(cnt_q)));
        cnt_d     = cnt_q + 1'b1;
`ifdef BOOTRAM_LOCK_EN
        if (lock_i) pend_d = 1'b1;
`endif
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_READY;
`ifdef BOOTRAM_LOCK_EN
          if (pend_q || lock_i) state_d = ST_LOCKED;
`endif
        end
      end
      default: begin
        gnt_o    = req_i;
        rvalid_d = req_i;
        mem_re   = req_i & ~we_i;
`ifdef BOOTRAM_LOCK_EN
        // A write granted in the same cycle lock_i is sampled still lands.
        if (state_q == ST_LOCKED) begin
          err_d = req_i & we_i & (|be_i);
        end else begin
          mem_we = req_i & we_i;
          if (lock_i) state_d = ST_LOCKED;
        end
`else
        mem_we = req_i & we_i;
`endif
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ST_INIT;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
`ifdef BOOTRAM_LOCK_EN
      pend_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
`ifdef BOOTRAM_LOCK_EN
      pend_q   <= pend_d;
`endif
    end
  end

  bootram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (mem_we & rst_ni),
    .re_i    (mem_re),
    .be_i    (mem_be),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .rdata_o (rdata_o)
  );

  assign rvalid_o    = rvalid_q;
  assign err_o       = err_q;
  assign init_done_o = (state_q != ST_INIT);
`ifdef BOOTRAM_LOCK_EN
  assign locked_o    = (state_q == ST_LOCKED);
`else
  assign locked_o    = 1'b0;
`endif

endmodule

// File: tb/tb_bootram_obi.sv
// tb/tb_bootram_obi.sv - self-checking bench for bootram_obi with a word-array reference model
module tb_bootram_obi;

`ifdef BOOTRAM_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [3:0]  be_i = '0;
  logic [3:0]  addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        lock_i = 1'b0;
  logic        gnt_o, rvalid_o, err_o, locked_o, init_done_o;
  logic [31:0] rdata_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] mdl [16];
  bit          mlock;
  logic [31:0] img [3] = '{32'h800002b7, 32'h00028313, 32'h00028067};

  bootram_obi #(.ADDR_W(4), .DATA_W(32)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .we_i        (we_i),
    .be_i        (be_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .gnt_o       (gnt_o),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .lock_i      (lock_i),
    .locked_o    (locked_o),
    .init_done_o (init_done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < 16; i++) mdl[i] = (i < 3) ? img[i] : 32'h0;
    mlock = 1'b0;
  endtask

  // One bus cycle: drive at negedge, check grant, then check the response after the edge.
  task automatic op(input bit req, input bit we, input logic [3:0] be,
                    input logic [3:0] addr, input logic [31:0] wd, input bit lk);
    logic [31:0] exp_rd;
    bit          exp_err;
    @(negedge clk);
    req_i = req; we_i = we; be_i = be; addr_i = addr; wdata_i = wd; lock_i = lk;
    #1;
    chk("gnt", {31'b0, gnt_o}, {31'b0, req});
    exp_rd  = (req && !we) ? mdl[addr] : 32'h0;
    exp_err = req && we && mlock && (be != 4'h0);
    if (req && we && !mlock)
      for (int b = 0; b < 4; b++) if (be[b]) mdl[addr][8*b +: 8] = wd[8*b +: 8];
    if (lk && LOCK_EN) mlock = 1'b1;
    @(posedge clk);
    #1;
    chk("rvalid", {31'b0, rvalid_o}, {31'b0, req});
    chk("rdata", rdata_o, exp_rd);
    chk("err", {31'b0, err_o}, {31'b0, exp_err});
    chk("locked", {31'b0, locked_o}, {31'b0, mlock});
  endtask

  // Caller holds rst_ni low with a read of word 0 pending; called #1 after a posedge.
  task automatic wait_init(input int lock_at);
    int k;
    bit gnt_seen;
    k = 0;
    gnt_seen = 1'b0;
    rst_ni = 1'b1;
    while (k < 40) begin
      @(posedge clk);
      #1;
      k++;
      if (init_done_o) break;
      if (gnt_o) gnt_seen = 1'b1;
      lock_i = (k == lock_at);
    end
    lock_i = 1'b0;
    chk("init_latency", k, 16);
    chk("gnt_during_init", {31'b0, gnt_seen}, 32'h0);
    mdl_reset();
    if (lock_at >= 0 && LOCK_EN) mlock = 1'b1;
    chk("locked_at_init_done", {31'b0, locked_o}, {31'b0, mlock});
    chk("gnt_after_init", {31'b0, gnt_o}, 32'h1);
    @(posedge clk);
    #1;
    chk("first_rvalid", {31'b0, rvalid_o}, 32'h1);
    chk("first_rdata", rdata_o, 32'h800002b7);
  endtask

  initial begin
    mdl_reset();
    rst_ni = 1'b0; req_i = 1'b1; we_i = 1'b0; addr_i = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_init_done", {31'b0, init_done_o}, 32'h0);
    chk("rst_rvalid", {31'b0, rvalid_o}, 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_err", {31'b0, err_o}, 32'h0);
    chk("rst_locked", {31'b0, locked_o}, 32'h0);
    chk("rst_gnt", {31'b0, gnt_o}, 32'h0);
    wait_init(-1);

    op(1, 0, 4'h0, 4'd1, 32'h0, 0);
    chk("img_word1", rdata_o, 32'h00028313);
    op(1, 0, 4'h0, 4'd2, 32'h0, 0);
    chk("img_word2", rdata_o, 32'h00028067);
    op(1, 0, 4'h0, 4'd3, 32'h0, 0);
    op(1, 0, 4'h0, 4'd15, 32'h0, 0);

    op(1, 1, 4'hF, 4'd5, 32'hDEADBEEF, 0);
    op(1, 0, 4'h0, 4'd5, 32'h0, 0);
    chk("w5_full", rdata_o, 32'hDEADBEEF);
    op(1, 1, 4'h2, 4'd5, 32'h00001200, 0);
    op(1, 0, 4'h0, 4'd5, 32'h0, 0);
    chk("w5_byte", rdata_o, 32'hDEAD12EF);
    op(1, 1, 4'h0, 4'd5, 32'hFFFFFFFF, 0);
    op(1, 0, 4'h0, 4'd5, 32'h0, 0);

    for (int i = 0; i < 300; i++)
      op($urandom_range(3) != 0, $urandom_range(1), 4'($urandom), 4'($urandom), $urandom, 0);

    op(0, 0, 4'h0, 4'd0, 32'h0, 1);
    op(1, 1, 4'hF, 4'd0, 32'h12345678, 0);
    chk("locked_write_err", {31'b0, err_o}, {31'b0, LOCK_EN});
    op(1, 0, 4'h0, 4'd0, 32'h0, 0);
    op(1, 1, 4'h0, 4'd3, 32'hA5A5A5A5, 0);
    for (int i = 0; i < 100; i++)
      op($urandom_range(3) != 0, $urandom_range(1), 4'($urandom), 4'($urandom), $urandom,
         $urandom_range(15) == 0);

    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = 4'd0; lock_i = 1'b0; rst_ni = 1'b0;
    @(posedge clk);
    #1;
    chk("dropped_rvalid", {31'b0, rvalid_o}, 32'h0);
    chk("dropped_rdata", rdata_o, 32'h0);
    rst_ni = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    chk("mid_init_done", {31'b0, init_done_o}, 32'h0);
    rst_ni = 1'b0;
    @(posedge clk);
    #1;
    wait_init(-1);
    op(1, 0, 4'h0, 4'd5, 32'h0, 0);

    rst_ni = 1'b0;
    req_i = 1'b1; we_i = 1'b0; addr_i = 4'd0; lock_i = 1'b0;
    @(posedge clk);
    #1;
    wait_init(3);
    op(1, 1, 4'hF, 4'd0, 32'h12345678, 0);
    op(1, 0, 4'h0, 4'd0, 32'h0, 0);
    op(1, 1, 4'h0, 4'd1, 32'h0, 0);
    op(0, 0, 4'h0, 4'd0, 32'h0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
